// File: rtl/mp_pkg.sv
// Shared widths and the compare helper for the max-pool pack block.
package mp_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IFM_W  = 9;
  // Column/row counter width: covers up to 26 pooled columns/rows.
  localparam int unsigned CNT_W  = 5;

  // Larger of two values under the selected signedness; ties return b (same value).
  function automatic logic [DATA_W-1:0] mp_max(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              is_signed);
    logic a_gt;
    if (is_signed) a_gt = ($signed(a) > $signed(b));
    else           a_gt = (a > b);
    return a_gt ? a : b;
  endfunction

endpackage

// File: rtl/mp_max_pool_pack_if.sv
// Window stream in, packed-word stream and status out.
interface mp_max_pool_pack_if #(
  parameter int unsigned DATA_W = 16
);
  logic              mp_valid;
  logic [DATA_W-1:0] mp_data0;
  logic [DATA_W-1:0] mp_data1;
  logic [DATA_W-1:0] mp_data2;
  logic [DATA_W-1:0] mp_data3;
  logic              out_full;
  logic              out_wr_en;
  logic [2*DATA_W-1:0] out_data;
  logic              row_done;
  logic              frame_done;
  logic              overflow;

  // Pooling block side.
  modport slave (
    input  mp_valid, mp_data0, mp_data1, mp_data2, mp_data3, out_full,
    output out_wr_en, out_data, row_done, frame_done, overflow
  );

  // Window source / downstream FIFO side.
  modport master (
    output mp_valid, mp_data0, mp_data1, mp_data2, mp_data3, out_full,
    input  out_wr_en, out_data, row_done, frame_done, overflow
  );
endinterface

// File: rtl/mp_out_fifo.sv
// Synchronous output buffer; head word is held in the storage register array.
module mp_out_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_fire_c, rd_fire_c;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_fire_c = rd_en_i && !empty_o;
  // A full buffer still accepts a write when a read frees a slot in the same cycle.
  assign wr_fire_c = wr_en_i && (!full_o || rd_fire_c);
  assign dout_o    = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire_c) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_fire_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_fire_c, rd_fire_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mp_max_pool_pack.sv
// 2x2 max-pool reduction, pair packing into 32-bit words and output buffering.
module mp_max_pool_pack #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SIGNED_CMP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] ifm_width,
  mp_max_pool_pack_if.slave bus
);
  import mp_pkg::*;

  localparam logic IS_SIGNED = (SIGNED_CMP != 0);

  logic              s1_valid_q, s2_valid_q;
  logic [DATA_W-1:0] m01_q, m23_q, pooled_q, low_q;
  logic [CNT_W-1:0]  col_q, row_q, half_q;
  logic [CNT_W-1:0]  col_d, row_d, half_c;
  logic              last_col_c, last_row_c, push_c, pop_c;
  logic [2*DATA_W-1:0] word_c;
  logic              overflow_q, full_c, empty_c;

  // Row length is taken live at frame start and frozen for the rest of the frame.
  always_comb begin
    half_c     = (col_q == '0 && row_q == '0) ? CNT_W'(ifm_width >> 1) : half_q;
    last_col_c = (col_q == half_c - CNT_W'(1));
    last_row_c = (row_q == half_c - CNT_W'(1));
    push_c     = s2_valid_q && (col_q[0] || last_col_c);
    word_c     = col_q[0] ? {pooled_q, low_q} : {{DATA_W{1'b0}}, pooled_q};
    col_d      = col_q;
    row_d      = row_q;
    if (s2_valid_q) begin
      if (last_col_c) begin
        col_d = '0;
        row_d = last_row_c ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  assign pop_c          = !empty_c && !bus.out_full;
  assign bus.out_wr_en  = pop_c;
  assign bus.row_done   = s2_valid_q && last_col_c;
  assign bus.frame_done = s2_valid_q && last_col_c && last_row_c;
  assign bus.overflow   = overflow_q;

  // Compare tree, pack state, position counters and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      m01_q      <= '0;
      m23_q      <= '0;
      pooled_q   <= '0;
      low_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      half_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.mp_valid;
      if (bus.mp_valid) begin
        m01_q <= mp_max(bus.mp_data0, bus.mp_data1, IS_SIGNED);
        m23_q <= mp_max(bus.mp_data2, bus.mp_data3, IS_SIGNED);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) pooled_q <= mp_max(m01_q, m23_q, IS_SIGNED);
      if (s2_valid_q && !col_q[0]) low_q <= pooled_q;
      col_q  <= col_d;
      row_q  <= row_d;
      half_q <= half_c;
      if (push_c && full_c && !pop_c) overflow_q <= 1'b1;
    end
  end

  mp_out_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (push_c),
    .din_i   (word_c),
    .rd_en_i (pop_c),
    .dout_o  (bus.out_data),
    .full_o  (full_c),
    .empty_o (empty_c)
  );
endmodule

// File: tb/tb_mp_max_pool_pack.sv
// Directed bench for mp_max_pool_pack: signed and unsigned instances share stimulus.
module tb_mp_max_pool_pack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] ifm_width = 9'd26;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mp_max_pool_pack_if #(.DATA_W(16)) bus_s ();
  mp_max_pool_pack_if #(.DATA_W(16)) bus_u ();

  mp_max_pool_pack #(.DATA_W(16), .FIFO_DEPTH(8), .SIGNED_CMP(1)) u_dut_s (
    .clk(clk), .rst(rst), .ifm_width(ifm_width), .bus(bus_s)
  );
  mp_max_pool_pack #(.DATA_W(16), .FIFO_DEPTH(8), .SIGNED_CMP(0)) u_dut_u (
    .clk(clk), .rst(rst), .ifm_width(ifm_width), .bus(bus_u)
  );

  int n_chk = 0;
  int n_err = 0;

  // Output monitor state.
  logic [31:0] wq[$];
  logic [31:0] uq[$];
  int rows = 0, frames = 0, rows_at_frame = 0, first_cyc = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_s.out_wr_en) begin
        if (first_cyc < 0) first_cyc = cyc;
        wq.push_back(bus_s.out_data);
      end
      if (bus_u.out_wr_en) uq.push_back(bus_u.out_data);
      if (bus_s.row_done) rows++;
      if (bus_s.frame_done) begin
        frames++;
        rows_at_frame = rows;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wget(input int i);
    return (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] uget(input int i);
    return (i < uq.size()) ? uq[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_full(input logic f);
    bus_s.out_full = f;
    bus_u.out_full = f;
  endtask

  task automatic win(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] c, input logic [15:0] d);
    bus_s.mp_valid = 1'b1; bus_u.mp_valid = 1'b1;
    bus_s.mp_data0 = a; bus_u.mp_data0 = a;
    bus_s.mp_data1 = b; bus_u.mp_data1 = b;
    bus_s.mp_data2 = c; bus_u.mp_data2 = c;
    bus_s.mp_data3 = d; bus_u.mp_data3 = d;
    step();
  endtask

  task automatic idle(input int n);
    bus_s.mp_valid = 1'b0; bus_u.mp_valid = 1'b0;
    bus_s.mp_data0 = '0; bus_u.mp_data0 = '0;
    bus_s.mp_data1 = '0; bus_u.mp_data1 = '0;
    bus_s.mp_data2 = '0; bus_u.mp_data2 = '0;
    bus_s.mp_data3 = '0; bus_u.mp_data3 = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_full(1'b0);
    idle(2);
    rst = 1'b0;
    wq.delete();
    uq.delete();
    rows = 0;
    frames = 0;
    rows_at_frame = 0;
    first_cyc = -1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_en"},    32'(bus_s.out_wr_en),  32'd0);
    chk({tag, "_data"},     bus_s.out_data,        32'd0);
    chk({tag, "_row_done"}, 32'(bus_s.row_done),   32'd0);
    chk({tag, "_frm_done"}, 32'(bus_s.frame_done), 32'd0);
    chk({tag, "_overflow"}, 32'(bus_s.overflow),   32'd0);
  endtask

  // Full frame of incrementing windows; window k = (4k..4k+3), pooled = 4k+3.
  task automatic run_frame(input int w, input string tag);
    int half;
    logic [31:0] exp_q[$];
    half = w / 2;
    ifm_width = 9'(w);
    for (int k = 0; k < half * half; k++)
      win(16'(4*k), 16'(4*k + 1), 16'(4*k + 2), 16'(4*k + 3));
    idle(20);
    for (int r = 0; r < half; r++) begin
      for (int c = 0; c < half; c += 2) begin
        int k;
        k = r * half + c;
        if (c + 1 < half) exp_q.push_back({16'(4*(k + 1) + 3), 16'(4*k + 3)});
        else              exp_q.push_back({16'h0000, 16'(4*k + 3)});
      end
    end
    for (int i = 0; i < exp_q.size(); i++) chk({tag, "_word"}, wget(i), exp_q[i]);
  endtask

  int cb;

  initial begin
    bus_s.out_full = 1'b0; bus_u.out_full = 1'b0;
    idle(1);
    do_reset();
    chk_reset_state("rst0");

    // Pair latency and packing order.
    ifm_width = 9'd26;
    win(16'd3, 16'hFFF9, 16'd12, 16'd5);
    cb = cyc;
    win(16'd1, 16'd2, 16'h7FFF, 16'd4);
    idle(8);
    chk("t1_nwords", 32'(wq.size()), 32'd1);
    chk("t1_word",   wget(0), 32'h7FFF_000C);
    chk("t1_lat",    32'(first_cyc - cb), 32'd3);
    chk("t1_uword",  uget(0), 32'h7FFF_FFF9);

    // Signed vs unsigned comparison.
    do_reset();
    win(16'h8000, 16'hFFFF, 16'h8001, 16'hFFFE);
    win(16'h8000, 16'h0001, 16'h0002, 16'h0003);
    idle(8);
    chk("t2_sword", wget(0), 32'h0003_FFFF);
    chk("t2_uword", uget(0), 32'h8000_FFFF);

    // Odd pooled row length: padded last word per row.
    do_reset();
    run_frame(26, "t3");
    chk("t3_nwords",    32'(wq.size()), 32'd91);
    chk("t3_first",     wget(0),  32'h0007_0003);
    chk("t3_row0_pad",  wget(6),  32'h0000_0033);
    chk("t3_last",      wget(90), 32'h0000_02A3);
    chk("t3_rows",      32'(rows),  32'd13);
    chk("t3_frames",    32'(frames), 32'd1);
    chk("t3_frm_align", 32'(rows_at_frame), 32'd13);

    // Even pooled row length: no padding.
    do_reset();
    run_frame(52, "t4");
    chk("t4_nwords",    32'(wq.size()), 32'd338);
    chk("t4_row0_last", wget(12),  32'h0067_0063);
    chk("t4_last",      wget(337), 32'h0A8F_0A8B);
    chk("t4_rows",      32'(rows),  32'd26);
    chk("t4_frames",    32'(frames), 32'd1);
    chk("t4_frm_align", 32'(rows_at_frame), 32'd26);

    // Downstream stall: one word per window, 12 stalled cycles overrun 8 slots.
    do_reset();
    ifm_width = 9'd2;
    for (int i = 0; i < 20; i++) begin
      set_full(i < 12);
      win(16'(4*i), 16'(4*i + 1), 16'(4*i + 2), 16'(4*i + 3));
    end
    set_full(1'b0);
    idle(20);
    chk("t5_nwords",   32'(wq.size()), 32'd18);
    for (int i = 0; i < 18; i++) begin
      int k;
      k = (i < 8) ? i : i + 2;
      chk("t5_word", wget(i), {16'h0000, 16'(4*k + 3)});
    end
    chk("t5_overflow", 32'(bus_s.overflow), 32'd1);
    chk("t5_rows",     32'(rows),   32'd20);
    chk("t5_frames",   32'(frames), 32'd20);

    // Reset mid-row, then a fresh frame.
    do_reset();
    chk_reset_state("rst5");
    ifm_width = 9'd26;
    for (int k = 0; k < 5; k++) win(16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03);
    do_reset();
    chk_reset_state("rst6");
    for (int k = 0; k < 13; k++)
      win(16'(256 + 4*k), 16'(257 + 4*k), 16'(258 + 4*k), 16'(259 + 4*k));
    idle(10);
    chk("t6_nwords", 32'(wq.size()), 32'd7);
    chk("t6_first",  wget(0), 32'h0107_0103);
    chk("t6_last",   wget(6), 32'h0000_0133);
    chk("t6_rows",   32'(rows),   32'd1);
    chk("t6_frames", 32'(frames), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mp_max_pool_pack.md
Name: mp_max_pool_pack

Overview:
- Consumes the 2x2 window stream produced by the max-pool pre-processing stage: mp_valid plus four 16-bit values.
- Reduces each window to its maximum through a 2-stage compare tree.
- Packs pairs of pooled results into 32-bit words (first result in [15:0]), matching the feature-map memory word format.
- Pushes packed words into an output buffer that drains to the downstream write FIFO; also tracks row and frame boundaries.

Parameters:
- DATA_W, 16, width of one feature value (signed two's-complement fixed point).
- FIFO_DEPTH, 8, internal output buffer depth in 32-bit words (power of 2).
- SIGNED_CMP, 1, 1 = signed compare, 0 = unsigned compare.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ifm_width  in  9  input feature-map width (even); pooled row length = ifm_width/2, rows per frame = ifm_width/2
- mp_valid  in  1  window valid; no backpressure path upstream
- mp_data0..mp_data3  in  16 each  window values (up-left, up-right, down-left, down-right)
- out_full  in  1  downstream write FIFO full
- out_wr_en  out  1  write strobe to downstream FIFO
- out_data  out  32  packed pooled pair
- row_done  out  1  1-cycle pulse when the last word of a pooled row is pushed into the buffer
- frame_done  out  1  1-cycle pulse when the last word of a frame is pushed into the buffer
- overflow  out  1  sticky flag: a word was dropped because the buffer was full

Behaviour:
- Reset: all outputs 0; pipeline valids 0; pack half-register empty; column/row counters 0; buffer empty; overflow cleared. Reset mid-frame discards all in-flight data.
- Timing reference: let cycle t be the cycle in which mp_valid=1 is sampled.
- Stage 1 (registered at end of t): m01 = max(d0,d1), m23 = max(d2,d3).
- Stage 2 (registered at end of t+1): pooled = max(m01,m23).
- Compare rule: uses SIGNED_CMP. Ties select either operand; the result is identical either way. No saturation or width growth; output width = DATA_W.
- Pack stage, active when pooled is valid in cycle t+2:
  - col counts pooled values in the current row, range 0..ifm_width/2-1.
  - Even col: hold the value in the low-half register. If it is also the last column of the row (odd row length, e.g. ifm_width=26 gives 13), push {16'h0, pooled} immediately.
  - Odd col: push {pooled, low_half}.
  - At the last column, col wraps to 0 and row increments. row_done pulses in the push cycle. At the last row, row wraps to 0 and frame_done pulses together with row_done.
- ifm_width is sampled when col=0 and row=0. Changes mid-frame are ignored until the next frame.
- Buffer: synchronous FIFO with registered read data.
  - Push when the pack stage produces a word.
  - Pop when not empty and !out_full. out_wr_en and out_data are valid in the same cycle.
  - Earliest out_wr_en: cycle t+3 after the second window of a pair.
- Full buffer on push: the word is dropped and overflow is set and held until rst. Counters still advance so row/frame alignment is preserved.
- Simultaneous push and pop on a full buffer: allowed, no drop. Occupancy is unchanged.
- Empty buffer with out_full=0: out_wr_en=0.
- Throughput: one window per cycle sustained. The buffer only absorbs downstream stalls.

Decomposition:
- mp_pkg holds:
  - DATA_W and WORD_W=32
  - a max function parameterised on signedness
  - the counter width constant (5 bits, enough for 26 pooled columns)
- Sub-module mp_out_fifo: parameterised sync FIFO (WIDTH=32, DEPTH=FIFO_DEPTH) with full, empty and registered dout. The compare tree and packer stay in the top module.

Test Plan:
- Reset, then a single window d0=3,d1=-7,d2=12,d3=5 and its pair d=(1,2,0x7FFF,4), out_full=0 -> out_wr_en once at t+3 of the second window, out_data=0x7FFF000C.
- Signed check: window (0x8000,0xFFFF,0x8001,0xFFFE) -> pooled 0xFFFF. With SIGNED_CMP=0 the same window gives 0xFFFF. Window (0x8000,1,2,3) gives 0x0003 signed and 0x8000 unsigned.
- ifm_width=26, 13x13 windows of incrementing values -> 7 words per row, last word upper half 0x0000, 13 row_done pulses, 1 frame_done on the 91st word.
- ifm_width=52, 26x26 windows -> 13 words per row, no padding, frame_done on the 338th word.
- out_full=1 held for 12 cycles during a continuous stream with FIFO_DEPTH=8 -> buffer fills and overflow=1. After release, counters still give correct row_done spacing and overflow stays 1.
- Assert rst mid-row after 5 windows, restart the frame -> no stale low half. The first word equals the first pair of the new frame, and row_done appears after exactly ifm_width/2 new windows.
